mult_share_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational N-bit array multiplier between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the operands, drives the shared multiplier, registers the 2N-bit product, and returns the product on a single response channel tagged with the requester ID. Exactly one transaction is in flight at any time.

---
 rtl/mult_arb_pkg.sv | 24 ++
 rtl/mult_share_arbiter_mul.sv | 12 +
 rtl/mult_share_arbiter_rr_picker.sv | 32 +++
 rtl/mult_share_arbiter.sv | 121 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Build option: define MULT_ARB_ZERO_BYPASS_EN to skip CALC when an operand is zero.
package mult_arb_pkg;

   localparam int MULT_ARB_NREQ_MIN = 2;
   localparam int MULT_ARB_NREQ_MAX = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mult_arb_state_e;

   // Bits needed to encode values 0..value-1; at least 1 for value <= 2.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/mult_share_arbiter_mul.sv
// Combinational unsigned N x N multiplier with a full 2N-bit product.
module mult_comb #(
   parameter int N = 4
) (
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic [2*N-1:0] o_p
);

   assign o_p = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};

endmodule

// File: rtl/mult_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above the
// pointer, with wrap-around. Reusable by other shared-datapath arbiters.
module rr_picker #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] i_valid,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_idx
);

   logic w_found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      // Outer loop walks distance from the pointer, so the nearest valid wins.
      for (int k = 0; k < NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!w_found && i_valid[j] &&
                ((int'(i_ptr) + k == j) || (int'(i_ptr) + k == j + NREQ))) begin
               w_found    = 1'b1;
               o_grant[j] = 1'b1;
               o_idx      = IDW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one multiplier among NREQ requesters, one op in flight.
// Build option: MULT_ARB_ZERO_BYPASS_EN sends zero-operand requests straight to DONE.
module mult_share_arbiter
   import mult_arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int NREQ = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*N-1:0]        req_a,
   input  logic [NREQ*N-1:0]        req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [2*N-1:0]           rsp_p,
   output logic [clog2(NREQ)-1:0]   rsp_id,
   output logic [1:0]               dbg_state,
   output logic [clog2(NREQ)-1:0]   dbg_rr_ptr
);

   localparam int IDW = clog2(NREQ);

   if (NREQ < MULT_ARB_NREQ_MIN || NREQ > MULT_ARB_NREQ_MAX) begin : g_bad_nreq
      $error("mult_share_arbiter: NREQ out of range");
   end

   mult_arb_state_e r_state;
   logic [IDW-1:0]  r_rr_ptr;
   logic [IDW-1:0]  r_id;
   logic [N-1:0]    r_op_a;
   logic [N-1:0]    r_op_b;
   logic [2*N-1:0]  r_prod;

   logic [NREQ-1:0] w_valid_idle;
   logic [NREQ-1:0] w_grant;
   logic [IDW-1:0]  w_idx;
   logic            w_accept;
   logic [N-1:0]    w_a_sel;
   logic [N-1:0]    w_b_sel;
   logic [2*N-1:0]  w_prod;

   // Handshake: a transfer happens on an edge where valid && ready are both high.
   assign w_valid_idle = (r_state == ST_IDLE) ? req_valid : '0;

   rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
      .i_valid (w_valid_idle),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   assign w_accept  = |w_grant;
   assign req_ready = rst_n ? w_grant : '0;

   always_comb begin
      w_a_sel = '0;
      w_b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_a_sel = req_a[i*N +: N];
            w_b_sel = req_b[i*N +: N];
         end
      end
   end

   // Multiplier sees only the registered operands, never the request bus.
   mult_comb #(.N(N)) u_mul (
      .i_a (r_op_a),
      .i_b (r_op_b),
      .o_p (w_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_id     <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_prod   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op_a   <= w_a_sel;
                  r_op_b   <= w_b_sel;
                  r_id     <= w_idx;
                  r_rr_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
`ifdef MULT_ARB_ZERO_BYPASS_EN
                  if (w_a_sel == '0 || w_b_sel == '0) begin
                     r_prod  <= '0;
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_CALC;
                  end
`else
                  r_state  <= ST_CALC;
`endif
               end
            end
            ST_CALC: begin
               r_prod  <= w_prod;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               if (rsp_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rsp_valid  = (r_state == ST_DONE);
   assign rsp_p      = r_prod;
   assign rsp_id     = r_id;
   assign dbg_state  = r_state;
   assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter (N=4, NREQ=2): vector table,
// hand-written corner sequences and a response scoreboard.
module tb_mult_share_arbiter;
   import mult_arb_pkg::*;

   localparam int N    = 4;
   localparam int NREQ = 2;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [2*N-1:0]    rsp_p;
   logic [0:0]        rsp_id;
   logic [1:0]        dbg_state;
   logic [0:0]        dbg_rr_ptr;

   mult_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_p      (rsp_p),
      .rsp_id     (rsp_id),
      .dbg_state  (dbg_state),
      .dbg_rr_ptr (dbg_rr_ptr)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_rsp    = 0;
   int cyc      = 0;
   int hs_cyc[$];
   logic [8:0] exp_q[$];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard: compare every response handshake against the expected queue
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         n_rsp++;
         hs_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d p %0h expected none", rsp_id, rsp_p);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("rsp_p", 32'(rsp_p), 32'(e[7:0]));
            check("rsp_id", 32'(rsp_id), 32'(e[8]));
         end
      end
   end

   function automatic int exp_lat(input logic [3:0] a, input logic [3:0] b);
`ifdef MULT_ARB_ZERO_BYPASS_EN
      if (a == 4'd0 || b == 4'd0) return 0;
`endif
      return 1;
   endfunction

   task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
      if (id == 0) begin
         req_a[3:0] = a;
         req_b[3:0] = b;
      end else begin
         req_a[7:4] = a;
         req_b[7:4] = b;
      end
   endtask

   // driver: one request from requester id, returns once rsp_valid is seen
   task automatic xact(input int id, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] p);
      int lat;
      int wait_n;
      logic [0:0] id_b;
      id_b = id[0];
      @(posedge clk); #1;
      set_ops(id, a, b);
      req_valid[id] = 1'b1;
      exp_q.push_back({id_b, p});
      wait_n = 0;
      do begin
         @(negedge clk);
         wait_n++;
      end while (!req_ready[id] && wait_n < 20);
      check("req_ready_grant", 32'(req_ready[id]), 32'd1);
      if (!req_ready[id]) begin
         void'(exp_q.pop_back());
         req_valid[id] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      check("rr_ptr", 32'(dbg_rr_ptr), 32'((id + 1) % NREQ));
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat(a, b)));
   endtask

   typedef struct {
      int         id;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int target;
      int wait_n;
      int k;

      vecs[0] = '{0, 4'hF, 4'hF, 8'hE1};
      vecs[1] = '{1, 4'h3, 4'h5, 8'h0F};
      vecs[2] = '{0, 4'h7, 4'h9, 8'h3F};
      vecs[3] = '{1, 4'h8, 4'h8, 8'h40};
      vecs[4] = '{0, 4'h1, 4'hF, 8'h0F};
      vecs[5] = '{1, 4'hF, 4'h1, 8'h0F};
      vecs[6] = '{0, 4'hC, 4'hD, 8'h9C};
      vecs[7] = '{1, 4'h2, 4'h8, 8'h10};

      // reset state, with requests present to show req_ready is forced low
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = 8'h57;
      req_b     = 8'h9A;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_p", 32'(rsp_p), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // table-driven single transactions (last entry is id 1, leaving rr_ptr=0)
      for (int i = 0; i < 8; i++) xact(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p);

      // both requesters valid continuously: expect 0,1,0,1 every 3 cycles
      @(posedge clk); #1;
      set_ops(0, 4'd3, 4'd5);
      set_ops(1, 4'd7, 4'd9);
      req_valid = 2'b11;
      exp_q.push_back({1'b0, 8'd15});
      exp_q.push_back({1'b1, 8'd63});
      exp_q.push_back({1'b0, 8'd15});
      exp_q.push_back({1'b1, 8'd63});
      target = n_rsp + 4;
      wait_n = 0;
      while (n_rsp < target && wait_n < 40) begin
         @(posedge clk); #1;
         wait_n++;
      end
      req_valid = '0;
      check("rr_rsp_count", 32'(n_rsp), 32'(target));
      k = hs_cyc.size();
      for (int i = k - 3; i < k; i++) check("rr_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);

      // backpressure: hold rsp_ready low for 10 cycles
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      set_ops(0, 4'd6, 4'd6);
      req_valid[0] = 1'b1;
      exp_q.push_back({1'b0, 8'd36});
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b11;
      wait_n = 0;
      while (!rsp_valid && wait_n < 10) begin
         @(posedge clk); #1;
         wait_n++;
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_p", 32'(rsp_p), 32'd36);
         check("bp_req_ready_low", 32'(req_ready), 32'd0);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_state", 32'(dbg_state), 32'(ST_IDLE));
      check("bp_release_valid", 32'(rsp_valid), 32'd0);

      // zero operands: product 0, latency depends on the bypass build option
      xact(1, 4'h0, 4'hA, 8'h00);
      xact(0, 4'h5, 4'h0, 8'h00);

      // reset while in CALC: transaction discarded, rr_ptr back to 0
      @(posedge clk); #1;
      set_ops(0, 4'd9, 4'd9);
      req_valid[0] = 1'b1;
      @(negedge clk);
      check("calc_req_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b11;
      check("calc_state", 32'(dbg_state), 32'(ST_CALC));
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_rsp_p", 32'(rsp_p), 32'd0);
      check("midrst_rsp_id", 32'(rsp_id), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("midrst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      xact(0, 4'd2, 4'd3, 8'd6);

      // exhaustive operand sweep through requester 1
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            logic [7:0] p;
            p = 8'(a * b);
            xact(1, 4'(a), 4'(b), p);
         end
      end

      @(posedge clk); #1;
      @(posedge clk); #1;
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
